ppu_vram_port: RTL and testbench
================================

Name: ppu_vram_port

Overview:
CPU-facing VRAM access port of the PPU, implementing the PPUADDR ($2006) and PPUDATA ($2007) register behaviour.
- Holds the 14-bit VRAM address register, the two-write address latch and the $2007 read buffer.
- Issues single-byte read/write transactions on a req/ack handshake. The raw address goes to ppu_mem_decode; data returns from PPU memory.
- Sits between the CPU register-bus decode and ppu_mem_decode.

Parameters:
- TIMEOUT, default 16: max cycles to wait for vram_ack before aborting a transaction.
- INC_ALT, default 32: increment applied when ctrl_inc32=1 (otherwise 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- reg_sel  in  3  CPU register index (6=PPUADDR, 7=PPUDATA); other values ignored
- reg_wr  in  1  one-cycle CPU write strobe
- reg_rd  in  1  one-cycle CPU read strobe
- reg_wdata  in  8  CPU write data
- status_rd  in  1  pulse on $2002 read; clears write toggle
- ctrl_inc32  in  1  PPUCTRL bit 2
- reg_rdata  out  8  $2007 read result
- rd_valid  out  1  one-cycle pulse; reg_rdata valid
- busy  out  1  transaction in flight
- err  out  1  one-cycle pulse on timeout abort
- vram_addr  out  16  raw PPU address to ppu_mem_decode, {2'b00, v[13:0]}
- vram_req  out  1  transaction request, held until ack
- vram_we  out  1  1=write, 0=read; valid with vram_req
- vram_wdata  out  8  write data
- vram_rdata  in  8  read data, valid in the vram_ack cycle
- vram_ack  in  1  transaction complete

Behaviour:
Reset values (asynchronous, rst_n=0): v=0, toggle=0, rbuf=8'h00, state=IDLE, and every output 0.
- A reset mid-transaction drops vram_req immediately; no rd_valid is produced.

Address writes (reg_sel=6, busy=0):
- toggle=0: v[13:8]=wdata[5:0]; toggle becomes 1.
- toggle=1: v[7:0]=wdata; toggle becomes 0.
- Writes take effect the next cycle.
- status_rd clears toggle. If it coincides with a $2006 write, the write uses the old toggle and the toggle ends at 0.

Strobe acceptance:
- Strobes with busy=1 are ignored with no side effects. The bus controller retries.
- reg_wr and reg_rd together: reg_wr wins.

State machine:
- IDLE
  - $2007 write: latch vram_wdata, go to WR.
  - $2007 read: go to RD.
- WR: vram_req=1, vram_we=1.
  - On ack: go to IDLE.
  - The cycle after ack: v increments.
- RD: vram_req=1, vram_we=0.
  - On ack: reg_rdata=old rbuf, rbuf=vram_rdata, rd_valid pulses the cycle after ack, v increments, go to IDLE.
- RD_PAL: only exists with the optional feature (see below).

Address increment and hold:
- Increment is 1, or INC_ALT when ctrl_inc32=1, sampled at ack.
- Arithmetic is 14-bit modulo: 0x3FFF+1 = 0x0000, 0x3FF0+32 = 0x0010.
- vram_addr, vram_we and vram_wdata are stable from req assertion until ack.

busy:
- 1 in every state except IDLE.
- Goes 0 the cycle after the final ack.

Timeout:
- A counter counts cycles in WR/RD/RD_PAL; it resets on state entry.
- If TIMEOUT cycles pass without ack: drop req, pulse err, return to IDLE.
- On abort: no v increment, no rbuf update, no rd_valid.

A $2006 write and a $2007 access can never overlap, because both are gated by busy.

Optional Feature:
Macro PPU_PALETTE_READ_BYPASS_EN.
- Defined: a $2007 read with v[13:8]==6'h3F runs in two phases.
  - RD fetches v: reg_rdata=fetched byte (no buffer delay).
  - RD_PAL then fetches {2'b00, v[13:0]} - 16'h1000: rbuf=that byte.
  - rd_valid pulses after the second ack; v increments once.
  - A timeout in either phase aborts the whole read.
- Undefined: palette reads behave like all other buffered reads; RD_PAL state is absent.

Decomposition:
- Shared package ppu_pkg: state encoding (IDLE, WR, RD, RD_PAL), register indices REG_PPUADDR=3'd6 and REG_PPUDATA=3'd7, PALETTE_HI=6'h3F, NT_MIRROR_OFS=16'h1000.
- One natural sub-module, ppu_vaddr_reg: v register, toggle, 14-bit increment logic.

Test Plan:
- Write $2006 0x21 then 0x08, $2007 0xAB with ack after 2 cycles -> vram_addr=0x2108, we=1, wdata=0xAB; v becomes 0x2109; busy drops the cycle after ack.
- Set address 0x2000, prime rbuf=0x00, read $2007 twice with memory returning 0x11 then 0x22 -> reg_rdata 0x00 then 0x11; addresses 0x2000 then 0x2001.
- ctrl_inc32=1, v=0x3FF0, write $2007 -> v=0x0010 (14-bit wrap); write $2006 0x7F -> v[13:8]=0x3F (bit 14 dropped).
- Single $2006 write, then status_rd, then $2006 0x12, 0x34 -> v=0x1234.
- Withhold ack for 16 cycles -> err pulse, req low, v unchanged, no rd_valid; a strobe issued while busy is ignored.
- Feature defined: v=0x3F05, palette byte 0x0C, underlying byte 0x5A -> reg_rdata=0x0C, fetch addresses 0x3F05 then 0x2F05, rbuf=0x5A, v=0x3F06. Feature undefined: reg_rdata = previous rbuf.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM access port.
// State encoding, CPU register indices and palette/mirror address constants.
package ppu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR     = 2'd1,
      RD     = 2'd2,
      RD_PAL = 2'd3
   } state_e;

   localparam logic [2:0]  REG_PPUADDR   = 3'd6;
   localparam logic [2:0]  REG_PPUDATA   = 3'd7;
   localparam logic [5:0]  PALETTE_HI    = 6'h3F;
   localparam logic [15:0] NT_MIRROR_OFS = 16'h1000;

   function automatic logic [13:0] vaddr_step(input logic inc32, input int alt);
      return inc32 ? 14'(alt) : 14'd1;
   endfunction

endpackage

// File: rtl/ppu_vaddr_reg.sv
// PPU VRAM address register v with the two-write $2006 toggle and 14-bit increment.
module ppu_vaddr_reg
   import ppu_pkg::*;
#(
   parameter int INC_ALT = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        addr_wr_i,
   input  logic [7:0]  wdata_i,
   input  logic        toggle_clr_i,
   input  logic        inc_en_i,
   input  logic        inc32_i,
   output logic [13:0] v_o
);

   logic [13:0] v_q, v_d;
   logic        toggle_q, toggle_d;

   // A coincident $2002 read still lets the write use the old toggle, then forces it low.
   always_comb begin
      v_d      = v_q;
      toggle_d = toggle_q;
      if (addr_wr_i) begin
         if (!toggle_q) begin
            v_d[13:8] = wdata_i[5:0];
            toggle_d  = 1'b1;
         end else begin
            v_d[7:0]  = wdata_i;
            toggle_d  = 1'b0;
         end
      end else if (inc_en_i) begin
         v_d = v_q + vaddr_step(inc32_i, INC_ALT);
      end
      if (toggle_clr_i) begin
         toggle_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q      <= 14'd0;
         toggle_q <= 1'b0;
      end else begin
         v_q      <= v_d;
         toggle_q <= toggle_d;
      end
   end

   assign v_o = v_q;

endmodule

// File: rtl/ppu_vram_port.sv
// CPU-facing PPUADDR/PPUDATA port: v register, $2007 read buffer and VRAM req/ack handshake.
// Optional macro PPU_PALETTE_READ_BYPASS_EN: unbuffered palette reads with a mirror refill fetch.
module ppu_vram_port
   import ppu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int INC_ALT = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  reg_sel,
   input  logic        reg_wr,
   input  logic        reg_rd,
   input  logic [7:0]  reg_wdata,
   input  logic        status_rd,
   input  logic        ctrl_inc32,
   output logic [7:0]  reg_rdata,
   output logic        rd_valid,
   output logic        busy,
   output logic        err,
   output logic [15:0] vram_addr,
   output logic        vram_req,
   output logic        vram_we,
   output logic [7:0]  vram_wdata,
   input  logic [7:0]  vram_rdata,
   input  logic        vram_ack
);

   state_e      state_q, state_d;
   logic [15:0] cnt_q;
   logic [7:0]  wdata_q, rbuf_q, rdata_q, rd_byte;
   logic        rd_valid_q, err_q;
   logic [13:0] v;
   logic        idle, addr_wr, data_wr, data_rd, timeout, pal_hit, rd_final, inc_en;

   assign idle     = (state_q == IDLE);
   assign addr_wr  = idle && reg_wr && (reg_sel == REG_PPUADDR);
   assign data_wr  = idle && reg_wr && (reg_sel == REG_PPUDATA);
   assign data_rd  = idle && !reg_wr && reg_rd && (reg_sel == REG_PPUDATA);
   assign timeout  = !idle && !vram_ack && (cnt_q == 16'(TIMEOUT - 1));
   assign rd_final = vram_ack && (((state_q == RD) && !pal_hit) || (state_q == RD_PAL));
   assign inc_en   = rd_final || (vram_ack && (state_q == WR));

`ifdef PPU_PALETTE_READ_BYPASS_EN
   logic [7:0] pal_q;

   assign pal_hit = (v[13:8] == PALETTE_HI);
   assign rd_byte = (state_q == RD_PAL) ? pal_q : rbuf_q;

   // The palette byte is held back until the mirror refill completes the read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pal_q <= 8'h00;
      end else if ((state_q == RD) && vram_ack) begin
         pal_q <= vram_rdata;
      end
   end
`else
   assign pal_hit = 1'b0;
   assign rd_byte = rbuf_q;
`endif

   ppu_vaddr_reg #(
      .INC_ALT      (INC_ALT)
   ) u_vaddr (
      .clk          (clk),
      .rst_n        (rst_n),
      .addr_wr_i    (addr_wr),
      .wdata_i      (reg_wdata),
      .toggle_clr_i (status_rd),
      .inc_en_i     (inc_en),
      .inc32_i      (ctrl_inc32),
      .v_o          (v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (data_wr) begin
               state_d = WR;
            end else if (data_rd) begin
               state_d = RD;
            end
         end
         WR: begin
            if (vram_ack || timeout) begin
               state_d = IDLE;
            end
         end
         RD: begin
            if (vram_ack && pal_hit) begin
               state_d = RD_PAL;
            end else if (vram_ack || timeout) begin
               state_d = IDLE;
            end
         end
`ifdef PPU_PALETTE_READ_BYPASS_EN
         RD_PAL: begin
            if (vram_ack || timeout) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = !idle;
      vram_req   = !idle;
      vram_we    = (state_q == WR);
      vram_wdata = wdata_q;
      vram_addr  = {2'b00, v};
`ifdef PPU_PALETTE_READ_BYPASS_EN
      if (state_q == RD_PAL) begin
         vram_addr = {2'b00, v} - NT_MIRROR_OFS;
      end
`endif
      reg_rdata  = rdata_q;
      rd_valid   = rd_valid_q;
      err        = err_q;
   end

   // The timeout counter restarts on every state entry, so each phase gets the full budget.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= 16'd0;
         wdata_q    <= 8'h00;
         rbuf_q     <= 8'h00;
         rdata_q    <= 8'h00;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= (idle || (state_d != state_q)) ? 16'd0 : cnt_q + 16'd1;
         rd_valid_q <= rd_final;
         err_q      <= timeout;
         if (data_wr) begin
            wdata_q <= reg_wdata;
         end
         if (rd_final) begin
            rdata_q <= rd_byte;
            rbuf_q  <= vram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Self-checking bench for ppu_vram_port: directed scenarios plus randomized traffic
// against a behavioural model of v, the write toggle, the read buffer and VRAM contents.
module tb_ppu_vram_port;

   localparam int TMO = 16;

   logic        clk, rst_n;
   logic [2:0]  reg_sel;
   logic        reg_wr, reg_rd, status_rd, ctrl_inc32;
   logic [7:0]  reg_wdata, reg_rdata;
   logic        rd_valid, busy, err;
   logic [15:0] vram_addr;
   logic        vram_req, vram_we, vram_ack;
   logic [7:0]  vram_wdata, vram_rdata;

   int          nChecks = 0;
   int          nPass   = 0;
   int          mV      = 0;
   bit          mToggle = 0;
   logic [7:0]  mRbuf   = 8'h00;
   logic [7:0]  mem [16384];

   ppu_vram_port #(.TIMEOUT(TMO), .INC_ALT(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reg_sel    (reg_sel),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .reg_wdata  (reg_wdata),
      .status_rd  (status_rd),
      .ctrl_inc32 (ctrl_inc32),
      .reg_rdata  (reg_rdata),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .err        (err),
      .vram_addr  (vram_addr),
      .vram_req   (vram_req),
      .vram_we    (vram_we),
      .vram_wdata (vram_wdata),
      .vram_rdata (vram_rdata),
      .vram_ack   (vram_ack)
   );

   always #5 clk = ~clk;

   task automatic model_addr_write(input logic [7:0] d);
      if (!mToggle) mV = (mV % 256) + (int'(d) % 64) * 256;
      else          mV = (mV / 256) * 256 + int'(d);
      mToggle = !mToggle;
   endtask

   task automatic cpu_strobe(input logic wr, input logic rd, input logic st,
                             input logic [2:0] sel, input logic [7:0] d);
      @(negedge clk);
      reg_wr = wr; reg_rd = rd; status_rd = st; reg_sel = sel; reg_wdata = d;
      @(negedge clk);
      reg_wr = 1'b0; reg_rd = 1'b0; status_rd = 1'b0;
   endtask

   task automatic set_addr(input logic [13:0] a);
      cpu_strobe(1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
      mToggle = 0;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, {2'b00, a[13:8]});
      model_addr_write({2'b00, a[13:8]});
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, a[7:0]);
      model_addr_write(a[7:0]);
   endtask

   // VRAM responder: waits (bounded) for req, holds off ack for 'delay' cycles, serves mem[].
   task automatic serve(input int delay, output logic [15:0] a, output logic w,
                        output logic [7:0] wd, output bit ok, output logic bsy);
      int guard = 0;
      ok = 1; a = 16'hxxxx; w = 1'bx; wd = 8'hxx; bsy = 1'bx;
      while (vram_req !== 1'b1 && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      if (vram_req !== 1'b1) begin
         ok = 0;
         return;
      end
      a = vram_addr; w = vram_we; wd = vram_wdata;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         if (vram_req !== 1'b1 || vram_addr !== a || vram_we !== w || vram_wdata !== wd) ok = 0;
      end
      bsy = busy;
      vram_ack = 1'b1;
      vram_rdata = mem[a[13:0]];
      if (w === 1'b1) mem[a[13:0]] = wd;
      @(negedge clk);
      vram_ack = 1'b0;
      vram_rdata = 8'($urandom);
   endtask

   task automatic test_reset();
      #12;
      nChecks++; if (reg_rdata !== 8'h00) $display("FAIL rst_rdata: got %h exp 00", reg_rdata); else nPass++;
      nChecks++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b exp 0", rd_valid); else nPass++;
      nChecks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else nPass++;
      nChecks++; if (err !== 1'b0) $display("FAIL rst_err: got %b exp 0", err); else nPass++;
      nChecks++; if (vram_addr !== 16'h0000) $display("FAIL rst_addr: got %h exp 0000", vram_addr); else nPass++;
      nChecks++; if (vram_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", vram_req); else nPass++;
      nChecks++; if (vram_we !== 1'b0) $display("FAIL rst_we: got %b exp 0", vram_we); else nPass++;
      nChecks++; if (vram_wdata !== 8'h00) $display("FAIL rst_wdata: got %h exp 00", vram_wdata); else nPass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      logic [15:0] a; logic w, bsy; logic [7:0] wd; bit ok;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h21); model_addr_write(8'h21);
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h08); model_addr_write(8'h08);
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd7, 8'hAB);
      serve(2, a, w, wd, ok, bsy);
      nChecks++; if (!ok || a !== 16'h2108 || w !== 1'b1 || wd !== 8'hAB)
         $display("FAIL wr_txn: got ok=%0d addr=%h we=%b data=%h exp addr=2108 we=1 data=AB", ok, a, w, wd); else nPass++;
      nChecks++; if (bsy !== 1'b1 || busy !== 1'b0)
         $display("FAIL wr_busy: got at_ack=%b after=%b exp 1/0", bsy, busy); else nPass++;
      mV = 16'h2109;
      nChecks++; if (vram_addr !== 16'h2109) $display("FAIL wr_vinc: got %h exp 2109", vram_addr); else nPass++;
   endtask

   task automatic test_buffered_read();
      logic [15:0] a; logic w, bsy; logic [7:0] wd; bit ok;
      ctrl_inc32 = 1'b0;
      set_addr(14'h1FFF);
      mem[14'h1FFF] = 8'h00; mem[14'h2000] = 8'h11; mem[14'h2001] = 8'h22;
      cpu_strobe(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
      serve(0, a, w, wd, ok, bsy);
      mRbuf = 8'h00; mV = 16'h2000;
      cpu_strobe(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
      serve(1, a, w, wd, ok, bsy);
      nChecks++; if (!ok || a !== 16'h2000 || w !== 1'b0)
         $display("FAIL rd1_txn: got ok=%0d addr=%h we=%b exp addr=2000 we=0", ok, a, w); else nPass++;
      nChecks++; if (rd_valid !== 1'b1 || reg_rdata !== 8'h00)
         $display("FAIL rd1_data: got valid=%b data=%h exp 1/00", rd_valid, reg_rdata); else nPass++;
      @(negedge clk);
      nChecks++; if (rd_valid !== 1'b0) $display("FAIL rd1_pulse: got %b exp 0", rd_valid); else nPass++;
      cpu_strobe(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
      serve(3, a, w, wd, ok, bsy);
      nChecks++; if (!ok || a !== 16'h2001 || w !== 1'b0)
         $display("FAIL rd2_txn: got ok=%0d addr=%h we=%b exp addr=2001 we=0", ok, a, w); else nPass++;
      nChecks++; if (rd_valid !== 1'b1 || reg_rdata !== 8'h11)
         $display("FAIL rd2_data: got valid=%b data=%h exp 1/11", rd_valid, reg_rdata); else nPass++;
      mRbuf = 8'h22; mV = 16'h2002;
   endtask

   task automatic test_inc_wrap();
      logic [15:0] a; logic w, bsy; logic [7:0] wd; bit ok;
      ctrl_inc32 = 1'b1;
      set_addr(14'h3FF0);
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd7, 8'h55);
      serve(0, a, w, wd, ok, bsy);
      nChecks++; if (!ok || a !== 16'h3FF0 || vram_addr !== 16'h0010)
         $display("FAIL inc32_wrap: got ok=%0d addr=%h v=%h exp 3FF0 then 0010", ok, a, vram_addr); else nPass++;
      ctrl_inc32 = 1'b0;
      set_addr(14'h3FFF);
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd7, 8'h66);
      serve(3, a, w, wd, ok, bsy);
      nChecks++; if (!ok || vram_addr !== 16'h0000)
         $display("FAIL inc1_wrap: got ok=%0d v=%h exp 0000", ok, vram_addr); else nPass++;
      mV = 0;
      cpu_strobe(1'b0, 1'b0, 1'b1, 3'd0, 8'h00); mToggle = 0;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h7F); model_addr_write(8'h7F);
      nChecks++; if (vram_addr !== 16'h3F00) $display("FAIL hi_mask: got %h exp 3F00", vram_addr); else nPass++;
   endtask

   task automatic test_status_toggle();
      cpu_strobe(1'b0, 1'b0, 1'b1, 3'd0, 8'h00); mToggle = 0;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h55); model_addr_write(8'h55);
      cpu_strobe(1'b0, 1'b0, 1'b1, 3'd0, 8'h00); mToggle = 0;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h12); model_addr_write(8'h12);
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h34); model_addr_write(8'h34);
      nChecks++; if (vram_addr !== 16'h1234) $display("FAIL status_clr: got %h exp 1234", vram_addr); else nPass++;
      cpu_strobe(1'b1, 1'b0, 1'b1, 3'd6, 8'h05); model_addr_write(8'h05); mToggle = 0;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h06); model_addr_write(8'h06);
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h78); model_addr_write(8'h78);
      nChecks++; if (vram_addr !== 16'h0678) $display("FAIL status_coinc0: got %h exp 0678", vram_addr); else nPass++;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h01); model_addr_write(8'h01);
      cpu_strobe(1'b1, 1'b0, 1'b1, 3'd6, 8'h9A); model_addr_write(8'h9A); mToggle = 0;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h02); model_addr_write(8'h02);
      nChecks++; if (vram_addr !== 16'h029A) $display("FAIL status_coinc1: got %h exp 029A", vram_addr); else nPass++;
   endtask

   task automatic test_timeout();
      logic [15:0] a; logic w, bsy; logic [7:0] wd; bit ok;
      int reqCycles = 0, errCycles = 0, rdvCycles = 0;
      logic [7:0] keepRbuf;
      set_addr(14'h0123);
      mem[14'h0123] = mRbuf ^ 8'hFF;
      keepRbuf = mRbuf;
      @(negedge clk);
      reg_sel = 3'd7; reg_rd = 1'b1;
      for (int i = 0; i < TMO + 6; i++) begin
         @(negedge clk);
         reg_rd = 1'b0; reg_wr = 1'b0;
         if (vram_req === 1'b1) reqCycles++;
         if (err === 1'b1) errCycles++;
         if (rd_valid === 1'b1) rdvCycles++;
         if (i == 3) begin reg_sel = 3'd6; reg_wdata = 8'hAA; reg_wr = 1'b1; end
         if (i == 5) begin reg_sel = 3'd7; reg_wdata = 8'hBB; reg_wr = 1'b1; end
      end
      nChecks++; if (reqCycles != TMO) $display("FAIL tmo_req_len: got %0d exp %0d", reqCycles, TMO); else nPass++;
      nChecks++; if (errCycles != 1) $display("FAIL tmo_err_pulse: got %0d exp 1", errCycles); else nPass++;
      nChecks++; if (rdvCycles != 0) $display("FAIL tmo_rd_valid: got %0d exp 0", rdvCycles); else nPass++;
      nChecks++; if (vram_addr !== 16'h0123 || busy !== 1'b0)
         $display("FAIL tmo_v_hold: got v=%h busy=%b exp 0123/0", vram_addr, busy); else nPass++;
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'h2A); model_addr_write(8'h2A);
      cpu_strobe(1'b1, 1'b0, 1'b0, 3'd6, 8'hBC); model_addr_write(8'hBC);
      nChecks++; if (vram_addr !== 16'h2ABC) $display("FAIL busy_ignore_toggle: got %h exp 2ABC", vram_addr); else nPass++;
      cpu_strobe(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
      serve(0, a, w, wd, ok, bsy);
      nChecks++; if (!ok || a !== 16'h2ABC || reg_rdata !== keepRbuf)
         $display("FAIL tmo_rbuf_hold: got ok=%0d addr=%h data=%h exp 2ABC/%h", ok, a, reg_rdata, keepRbuf); else nPass++;
      mRbuf = mem[14'h2ABC]; mV = 16'h2ABD;
   endtask

   task automatic test_palette();
      logic [15:0] a1, a2; logic w, bsy; logic [7:0] wd, prevRbuf; bit ok1, ok2;
      ctrl_inc32 = 1'b0;
      set_addr(14'h3F05);
      mem[14'h3F05] = 8'h0C; mem[14'h2F05] = 8'h5A; mem[14'h0200] = 8'hE7;
      prevRbuf = mRbuf;
      cpu_strobe(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
      serve(1, a1, w, wd, ok1, bsy);
`ifdef PPU_PALETTE_READ_BYPASS_EN
      nChecks++; if (rd_valid !== 1'b0) $display("FAIL pal_early_valid: got %b exp 0", rd_valid); else nPass++;
      serve(0, a2, w, wd, ok2, bsy);
      nChecks++; if (!ok1 || !ok2 || a1 !== 16'h3F05 || a2 !== 16'h2F05)
         $display("FAIL pal_addrs: got ok=%0d/%0d addr=%h/%h exp 3F05/2F05", ok1, ok2, a1, a2); else nPass++;
      nChecks++; if (rd_valid !== 1'b1 || reg_rdata !== 8'h0C)
         $display("FAIL pal_data: got valid=%b data=%h exp 1/0C", rd_valid, reg_rdata); else nPass++;
      mRbuf = 8'h5A;
`else
      ok2 = 1; a2 = 16'h0000;
      nChecks++; if (!ok1 || a1 !== 16'h3F05)
         $display("FAIL pal_addrs: got ok=%0d addr=%h exp 3F05", ok1, a1); else nPass++;
      nChecks++; if (rd_valid !== 1'b1 || reg_rdata !== prevRbuf)
         $display("FAIL pal_data: got valid=%b data=%h exp 1/%h", rd_valid, reg_rdata, prevRbuf); else nPass++;
      mRbuf = 8'h0C;
`endif
      mV = 16'h3F06;
      nChecks++; if (vram_addr !== 16'h3F06) $display("FAIL pal_vinc: got %h exp 3F06", vram_addr); else nPass++;
      set_addr(14'h0200);
      cpu_strobe(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
      serve(0, a1, w, wd, ok1, bsy);
`ifdef PPU_PALETTE_READ_BYPASS_EN
      nChecks++; if (!ok1 || reg_rdata !== 8'h5A) $display("FAIL pal_rbuf: got ok=%0d data=%h exp 5A", ok1, reg_rdata); else nPass++;
`else
      nChecks++; if (!ok1 || reg_rdata !== 8'h0C) $display("FAIL pal_rbuf: got ok=%0d data=%h exp 0C", ok1, reg_rdata); else nPass++;
`endif
      mRbuf = 8'hE7; mV = 16'h0201;
   endtask

   task automatic test_random();
      logic [15:0] a, a2; logic w, bsy; logic [7:0] wd, d, expData, newBuf; bit ok, aOk, pal, st;
      int op, step, delay;
      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 4);
         ctrl_inc32 = 1'($urandom_range(0, 1));
         step = ctrl_inc32 ? 32 : 1;
         d = 8'($urandom);
         delay = $urandom_range(0, 4);
         case (op)
            0: begin
               st = 1'($urandom_range(0, 1));
               cpu_strobe(1'b1, 1'b0, st, 3'd6, d);
               model_addr_write(d);
               if (st) mToggle = 0;
            end
            1: begin
               cpu_strobe(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, 5)), d);
               mToggle = 0;
            end
            2, 4: begin
               cpu_strobe(1'b1, op == 4, 1'b0, 3'd7, d);
               serve(delay, a, w, wd, ok, bsy);
               nChecks++; if (!ok || a !== 16'(mV) || w !== 1'b1 || wd !== d)
                  $display("FAIL rnd_write: got ok=%0d addr=%h we=%b data=%h exp %h/1/%h", ok, a, w, wd, 16'(mV), d); else nPass++;
               mV = (mV + step) % 16384;
            end
            default: begin
               pal = 0;
`ifdef PPU_PALETTE_READ_BYPASS_EN
               pal = ((mV / 256) == 63);
`endif
               if (pal) begin expData = mem[mV]; newBuf = mem[mV - 4096]; end
               else begin expData = mRbuf; newBuf = mem[mV]; end
               cpu_strobe(1'b0, 1'b1, 1'b0, 3'd7, d);
               serve(delay, a, w, wd, ok, bsy);
               aOk = ok && (a === 16'(mV)) && (w === 1'b0);
               if (pal) begin
                  serve(0, a2, w, wd, ok, bsy);
                  aOk = aOk && ok && (a2 === 16'(mV - 4096));
               end
               nChecks++; if (!aOk || rd_valid !== 1'b1 || reg_rdata !== expData)
                  $display("FAIL rnd_read: got ok=%0d addr=%h valid=%b data=%h exp %h/1/%h", aOk, a, rd_valid, reg_rdata, 16'(mV), expData); else nPass++;
               mRbuf = newBuf;
               mV = (mV + step) % 16384;
            end
         endcase
         nChecks++; if (vram_addr !== 16'(mV)) $display("FAIL rnd_v: got %h exp %h", vram_addr, 16'(mV)); else nPass++;
      end
   endtask

   task automatic test_reset_mid();
      cpu_strobe(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
      nChecks++; if (vram_req !== 1'b1) $display("FAIL mid_req_start: got %b exp 1", vram_req); else nPass++;
      #1 rst_n = 1'b0;
      #1;
      nChecks++; if (vram_req !== 1'b0 || busy !== 1'b0)
         $display("FAIL mid_req_drop: got req=%b busy=%b exp 0/0", vram_req, busy); else nPass++;
      @(negedge clk);
      rst_n = 1'b1;
      mV = 0; mToggle = 0; mRbuf = 8'h00;
      @(negedge clk);
      nChecks++; if (rd_valid !== 1'b0 || vram_addr !== 16'h0000 || reg_rdata !== 8'h00)
         $display("FAIL mid_after: got valid=%b v=%h data=%h exp 0/0000/00", rd_valid, vram_addr, reg_rdata); else nPass++;
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0;
      reg_sel = 3'd0; reg_wr = 1'b0; reg_rd = 1'b0; reg_wdata = 8'h00;
      status_rd = 1'b0; ctrl_inc32 = 1'b0;
      vram_ack = 1'b0; vram_rdata = 8'h00;
      for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
      test_reset();
      test_write();
      test_buffered_read();
      test_inc_wrap();
      test_status_toggle();
      test_timeout();
      test_palette();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
